// File: rtl/axilite_pkg.sv
// rtl/axilite_pkg.sv - AXI4-Lite response codes and responder FSM state types
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axilite_slave_regfile_if.sv
// rtl/axilite_slave_regfile_if.sv - AXI4-Lite bus bundle with master/slave views
interface axilite_slave_regfile_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axilite_strb_merge.sv
// rtl/axilite_strb_merge.sv - combinational byte-lane merge of old word, new word and strobe
module axilite_strb_merge #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged
);
    always_comb begin
        merged = old_data;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/axilite_slave_regfile.sv
// rtl/axilite_slave_regfile.sv - AXI4-Lite register file responder with fabric write port
// Optional AXIL_SLV_DECERR_EN: out-of-range addresses get DECERR instead of aliasing.
module axilite_slave_regfile
    import axilite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    axilite_slave_regfile_if.slave       s_axi,
    input  logic                         usr_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]  usr_wr_idx,
    input  logic [DATA_W-1:0]            usr_wr_data,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    wr_state_t         wr_state_q, wr_state_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              aw_err_q, aw_err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;

    rd_state_t         rd_state_q, rd_state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic              awready_int, wready_int, arready_int;
    logic              aw_hs, w_hs, ar_hs;
    logic              aw_err_now, ar_err_now;
    logic [IDX_W-1:0]  aw_idx_now, ar_idx_now;

    logic              commit_en, commit_err;
    logic [IDX_W-1:0]  commit_idx;
    logic [DATA_W-1:0] commit_data, commit_merged;
    logic [STRB_W-1:0] commit_strb;

    assign aw_idx_now = s_axi.awaddr[ADDR_LSB +: IDX_W];
    assign ar_idx_now = s_axi.araddr[ADDR_LSB +: IDX_W];

`ifdef AXIL_SLV_DECERR_EN
    assign aw_err_now = |s_axi.awaddr[ADDR_W-1:ADDR_LSB+IDX_W];
    assign ar_err_now = |s_axi.araddr[ADDR_W-1:ADDR_LSB+IDX_W];
`else
    assign aw_err_now = 1'b0;
    assign ar_err_now = 1'b0;
`endif

    // Prot bits and sub-word address bits carry no meaning for this register file.
    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr};

    // Readies are gated by reset so they sit low while aresetn is asserted.
    assign awready_int = aresetn && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_W);
    assign wready_int  = aresetn && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_AW);
    assign arready_int = aresetn && (rd_state_q == R_IDLE);

    assign aw_hs = s_axi.awvalid && awready_int;
    assign w_hs  = s_axi.wvalid  && wready_int;
    assign ar_hs = s_axi.arvalid && arready_int;

    always_comb begin
        wr_state_d  = wr_state_q;
        aw_idx_d    = aw_idx_q;
        aw_err_d    = aw_err_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        commit_en   = 1'b0;
        commit_idx  = aw_idx_q;
        commit_err  = aw_err_q;
        commit_data = wdata_q;
        commit_strb = wstrb_q;

        if (aw_hs) begin
            aw_idx_d = aw_idx_now;
            aw_err_d = aw_err_now;
        end
        if (w_hs) begin
            wdata_d = s_axi.wdata;
            wstrb_d = s_axi.wstrb;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_en   = 1'b1;
                    commit_idx  = aw_idx_now;
                    commit_err  = aw_err_now;
                    commit_data = s_axi.wdata;
                    commit_strb = s_axi.wstrb;
                end else if (aw_hs) begin
                    wr_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit_en   = 1'b1;
                    commit_data = s_axi.wdata;
                    commit_strb = s_axi.wstrb;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit_en  = 1'b1;
                    commit_idx = aw_idx_now;
                    commit_err = aw_err_now;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (commit_en) begin
            wr_state_d = W_RESP;
            bresp_d    = commit_err ? RESP_DECERR : RESP_OKAY;
        end
    end

    axilite_strb_merge #(.DATA_W(DATA_W)) u_strb_merge (
        .old_data (regs_q[commit_idx]),
        .new_data (commit_data),
        .strb     (commit_strb),
        .merged   (commit_merged)
    );

    // The AXI commit is applied last so it owns the whole word on an index clash.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (usr_wr_en) begin
            regs_d[usr_wr_idx] = usr_wr_data;
        end
        if (commit_en && !commit_err) begin
            regs_d[commit_idx] = commit_merged;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = ar_err_now ? '0 : regs_q[ar_idx_now];
                    rresp_d    = ar_err_now ? RESP_DECERR : RESP_OKAY;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axi.rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_state_q <= W_IDLE;
            aw_idx_q   <= '0;
            aw_err_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_state_q <= wr_state_d;
            aw_idx_q   <= aw_idx_d;
            aw_err_q   <= aw_err_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.awready = awready_int;
    assign s_axi.wready  = wready_int;
    assign s_axi.arready = arready_int;
    assign s_axi.bvalid  = (wr_state_q == W_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = (rd_state_q == R_RESP);
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// tb/tb_axilite_slave_regfile.sv - directed table, corner sequences and random model check for axilite_slave_regfile
module tb_axilite_slave_regfile;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          usr_wr_en;
    logic [3:0]    usr_wr_idx;
    logic [63:0]   usr_wr_data;
    logic [1023:0] regs_out;

    int checks = 0;
    int errors = 0;

    logic [63:0] mdl [16];

    axilite_slave_regfile_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axilite_slave_regfile #(.ADDR_W(32), .DATA_W(64), .NUM_REGS(16)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axi       (bus),
        .usr_wr_en   (usr_wr_en),
        .usr_wr_idx  (usr_wr_idx),
        .usr_wr_data (usr_wr_data),
        .regs_out    (regs_out)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] reg_at(input int i);
        return regs_out[i*64 +: 64];
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_fire, w_fire;
        int c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            if (!aw_done && c >= aw_dly) begin
                bus.awvalid = 1'b1;
                bus.awaddr  = addr;
            end
            if (!w_done && c >= w_dly) begin
                bus.wvalid = 1'b1;
                bus.wdata  = data;
                bus.wstrb  = strb;
            end
            if (w_done && !aw_done) chk("wready_low_have_w", {63'd0, bus.wready}, 64'd0);
            if (aw_done && !w_done) chk("awready_low_have_aw", {63'd0, bus.awready}, 64'd0);
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            step();
            if (aw_fire) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_fire)  begin w_done = 1;  bus.wvalid  = 1'b0; end
            c++;
        end
        chk("wr_handshake", {63'd0, aw_done && w_done}, 64'd1);
        chk("bvalid_after_commit", {63'd0, bus.bvalid}, 64'd1);
        for (int k = 0; k < b_dly; k++) begin
            step();
            chk("bvalid_hold", {63'd0, bus.bvalid}, 64'd1);
        end
        resp = bus.bresp;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        chk("bvalid_drop", {63'd0, bus.bvalid}, 64'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly,
                            output logic [63:0] data, output logic [1:0] resp);
        int c = 0;
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        while (!bus.arready && c < 50) begin
            step();
            c++;
        end
        chk("arready_idle", {63'd0, bus.arready}, 64'd1);
        step();
        bus.arvalid = 1'b0;
        chk("rvalid_latency", {63'd0, bus.rvalid}, 64'd1);
        chk("arready_busy", {63'd0, bus.arready}, 64'd0);
        data = bus.rdata;
        resp = bus.rresp;
        for (int k = 0; k < r_dly; k++) begin
            step();
            chk("rdata_stable", bus.rdata, data);
            chk("rvalid_hold", {63'd0, bus.rvalid}, 64'd1);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        chk("rvalid_drop", {63'd0, bus.rvalid}, 64'd0);
    endtask

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        int          dly_aw;
        int          dly_w;
        int          dly_resp;
        int          idx;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [5];

    logic [63:0]   rd_data;
    logic [1:0]    rsp;
    logic [1023:0] snap;
    bit            decerr_build;

    initial begin
`ifdef AXIL_SLV_DECERR_EN
        decerr_build = 1'b1;
`else
        decerr_build = 1'b0;
`endif
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        usr_wr_en = 1'b0; usr_wr_idx = '0; usr_wr_data = '0;

        vecs[0] = '{0, 32'h08, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 0, 1, 64'hDEADBEEF_CAFEF00D, "wr_same_cycle"};
        vecs[1] = '{0, 32'h10, 64'h11223344_55667788, 8'h0F, 3, 0, 4, 2, 64'h00000000_55667788, "wr_w_first"};
        vecs[2] = '{1, 32'h08, 64'h0, 8'h00, 0, 0, 5, 1, 64'hDEADBEEF_CAFEF00D, "rd_held"};
        vecs[3] = '{0, 32'h08, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 0, 2, 1, 1, 64'hDEADBEEF_CAFEF00D, "wr_strb0"};
        vecs[4] = '{0, 32'h0C, 64'h12345678_9ABCDEF0, 8'hF0, 1, 1, 0, 1, 64'h12345678_CAFEF00D, "wr_upper_lanes"};

        // reset state
        #12;
        chk("rst_awready", {63'd0, bus.awready}, 64'd0);
        chk("rst_wready", {63'd0, bus.wready}, 64'd0);
        chk("rst_arready", {63'd0, bus.arready}, 64'd0);
        chk("rst_bvalid", {63'd0, bus.bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        chk("rst_resps", {60'd0, bus.bresp, bus.rresp}, 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_regs", {63'd0, |regs_out}, 64'd0);
        #11 aresetn = 1'b1;
        step();
        chk("post_rst_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);

        // directed table
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_read) begin
                axi_read(vecs[i].addr, vecs[i].dly_resp, rd_data, rsp);
                chk({vecs[i].name, "_rdata"}, rd_data, vecs[i].exp);
                chk({vecs[i].name, "_rresp"}, {62'd0, rsp}, 64'd0);
            end else begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                          vecs[i].dly_aw, vecs[i].dly_w, vecs[i].dly_resp, rsp);
                chk({vecs[i].name, "_bresp"}, {62'd0, rsp}, 64'd0);
                chk({vecs[i].name, "_reg"}, reg_at(vecs[i].idx), vecs[i].exp);
            end
        end

        // AXI commit and fabric write to the same index: AXI wins
        bus.awvalid = 1'b1; bus.awaddr = 32'h08;
        bus.wvalid = 1'b1; bus.wdata = 64'hA5; bus.wstrb = 8'hFF;
        usr_wr_en = 1'b1; usr_wr_idx = 4'd1; usr_wr_data = 64'h5A5A_5A5A;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; usr_wr_en = 1'b0;
        chk("collide_axi_wins", reg_at(1), 64'hA5);
        chk("collide_bvalid", {63'd0, bus.bvalid}, 64'd1);
        bus.bready = 1'b1; step(); bus.bready = 1'b0;

        // different indices in the same cycle: both land
        bus.awvalid = 1'b1; bus.awaddr = 32'h20;
        bus.wvalid = 1'b1; bus.wdata = 64'h44; bus.wstrb = 8'hFF;
        usr_wr_en = 1'b1; usr_wr_idx = 4'd5; usr_wr_data = 64'h55;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; usr_wr_en = 1'b0;
        chk("both_axi_reg4", reg_at(4), 64'h44);
        chk("both_usr_reg5", reg_at(5), 64'h55);
        bus.bready = 1'b1; step(); bus.bready = 1'b0;

        // read and write of 0x18 in the same cycle: read sees old value
        bus.awvalid = 1'b1; bus.awaddr = 32'h18;
        bus.wvalid = 1'b1; bus.wdata = 64'h1818; bus.wstrb = 8'hFF;
        bus.arvalid = 1'b1; bus.araddr = 32'h18;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("rw_same_rvalid", {63'd0, bus.rvalid}, 64'd1);
        chk("rw_same_old_rdata", bus.rdata, 64'd0);
        chk("rw_same_reg3", reg_at(3), 64'h1818);
        bus.bready = 1'b1; bus.rready = 1'b1;
        step();
        bus.bready = 1'b0; bus.rready = 1'b0;
        axi_read(32'h18, 0, rd_data, rsp);
        chk("rw_followup_rdata", rd_data, 64'h1818);

        // fabric-only write lands on the next edge
        usr_wr_en = 1'b1; usr_wr_idx = 4'd3; usr_wr_data = 64'h3333;
        chk("usr_before_edge", reg_at(3), 64'h1818);
        step();
        usr_wr_en = 1'b0;
        chk("usr_after_edge", reg_at(3), 64'h3333);

        // out-of-range address
        snap = regs_out;
        axi_write(32'h100, 64'hBAD0_0000_0000_BAD0, 8'hFF, 0, 0, 0, rsp);
        if (decerr_build) begin
            chk("oor_bresp", {62'd0, rsp}, 64'd3);
            chk("oor_regs_unchanged", {63'd0, regs_out == snap}, 64'd1);
            axi_read(32'h100, 0, rd_data, rsp);
            chk("oor_rdata", rd_data, 64'd0);
            chk("oor_rresp", {62'd0, rsp}, 64'd3);
        end else begin
            chk("alias_bresp", {62'd0, rsp}, 64'd0);
            chk("alias_reg0", reg_at(0), 64'hBAD0_0000_0000_BAD0);
            axi_read(32'h100, 0, rd_data, rsp);
            chk("alias_rdata", rd_data, 64'hBAD0_0000_0000_BAD0);
            chk("alias_rresp", {62'd0, rsp}, 64'd0);
        end

        // random traffic against the model, from a clean reset
        #3 aresetn = 1'b0;
        #4 aresetn = 1'b1;
        step();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        chk("rand_start_regs", {63'd0, |regs_out}, 64'd0);

        for (int n = 0; n < 150; n++) begin
            int          op;
            int          idx;
            logic [31:0] addr;
            logic [63:0] data;
            logic [7:0]  strb;
            bit          err;
            op   = $urandom_range(0, 2);
            idx  = $urandom_range(0, 15);
            addr = ($urandom_range(0, 3) == 0) ? ($urandom_range(1, 255) << 7) : 32'd0;
            addr = addr + idx * 8 + $urandom_range(0, 7);
            err  = decerr_build && (addr >= 32'd128);
            data = {$urandom, $urandom};
            strb = 8'($urandom_range(0, 255));
            if (op == 0) begin
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), rsp);
                chk("rand_bresp", {62'd0, rsp}, err ? 64'd3 : 64'd0);
                if (!err) begin
                    for (int b = 0; b < 8; b++) begin
                        if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
                    end
                end
                chk("rand_wr_reg", reg_at(idx), mdl[idx]);
            end else if (op == 1) begin
                axi_read(addr, $urandom_range(0, 2), rd_data, rsp);
                chk("rand_rdata", rd_data, err ? 64'd0 : mdl[idx]);
                chk("rand_rresp", {62'd0, rsp}, err ? 64'd3 : 64'd0);
            end else begin
                usr_wr_en = 1'b1; usr_wr_idx = 4'(idx); usr_wr_data = data;
                step();
                usr_wr_en = 1'b0;
                mdl[idx] = data;
                chk("rand_usr_reg", reg_at(idx), mdl[idx]);
            end
        end
        for (int i = 0; i < 16; i++) chk("rand_final_reg", reg_at(i), mdl[i]);

        // async reset with both responses pending
        bus.awvalid = 1'b1; bus.awaddr = 32'h28;
        bus.wvalid = 1'b1; bus.wdata = 64'h77; bus.wstrb = 8'hFF;
        bus.arvalid = 1'b1; bus.araddr = 32'h28;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("pend_bvalid", {63'd0, bus.bvalid}, 64'd1);
        chk("pend_rvalid", {63'd0, bus.rvalid}, 64'd1);
        #2 aresetn = 1'b0;
        #1;
        chk("abort_bvalid", {63'd0, bus.bvalid}, 64'd0);
        chk("abort_rvalid", {63'd0, bus.rvalid}, 64'd0);
        chk("abort_regs", {63'd0, |regs_out}, 64'd0);
        chk("abort_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd0);
        #3 aresetn = 1'b1;
        step();
        chk("rerun_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
